// File: rtl/inst_decode.sv
// inst_decode: instruction decode / register-fetch stage of the multi-cycle core.
// It captures IR/NPC from fetch and reads rs1/rs2 from the 32x32 register file.
// It sign-extends the immediate and presents a one-cycle DEC_VALID bundle to
// execute. The block also owns the register file write-back port.
//
// Optional feature: define DECODE_BYPASS_EN to forward a write-back that
// lands on the READ edge straight into A/B.
//
// Ports:
//   CLK, RST                      clock, async active-high reset
//   IR_IN, NPC_IN, IR_VALID       instruction word / next-PC from fetch
//   WB_EN, WB_ADDR, WB_DATA       register file write port (any state)
//   A, B, IMM                     operands and sign-extended immediate
//   RD, OPCODE                    decoded from IR_OUT (combinational)
//   NPC_OUT, IR_OUT               captured fetch bundle
//   DEC_VALID                     bundle valid, one cycle in SEND
//   BUSY, ESTADO                  not-IDLE flag, state encoding (debug)
module inst_decode #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   IR_IN,
  input  logic [AW-1:0] NPC_IN,
  input  logic          IR_VALID,
  input  logic          WB_EN,
  input  logic [4:0]    WB_ADDR,
  input  logic [DW-1:0] WB_DATA,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] IMM,
  output logic [4:0]    RD,
  output logic [5:0]    OPCODE,
  output logic [AW-1:0] NPC_OUT,
  output logic [31:0]   IR_OUT,
  output logic          DEC_VALID,
  output logic          BUSY,
  output logic [1:0]    ESTADO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    READ  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] regs [NREG];
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic          fwd_a;
  logic          fwd_b;
  logic [DW-1:0] imm_c;

  // Field decode off the captured instruction.
  assign OPCODE = IR_OUT[31:26];
  assign rs1    = IR_OUT[25:21];
  assign rs2    = IR_OUT[20:16];
  assign RD     = (OPCODE == 6'h00) ? IR_OUT[15:11] : IR_OUT[20:16];
  assign ESTADO = state;

  // J/JAL carry a 26-bit immediate; everything else a 16-bit one.
  assign imm_c = (OPCODE == 6'h02 || OPCODE == 6'h03) ?
                 DW'($signed(IR_OUT[25:0])) : DW'($signed(IR_OUT[15:0]));

  // R0 reads as zero regardless of storage contents.
  assign rf_a = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rf_b = (rs2 == 5'd0) ? '0 : regs[rs2];

`ifdef DECODE_BYPASS_EN
  // Same-edge write-back to a source register is forwarded per operand.
  assign fwd_a = WB_EN && (WB_ADDR != 5'd0) && (WB_ADDR == rs1);
  assign fwd_b = WB_EN && (WB_ADDR != 5'd0) && (WB_ADDR == rs2);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Register file: writes to R0 are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= '{default: '0};
    end else if (WB_EN && (WB_ADDR != 5'd0)) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  // Decode FSM; operands and IR/NPC hold until the next capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      A         <= '0;
      B         <= '0;
      IMM       <= '0;
      NPC_OUT   <= '0;
      IR_OUT    <= '0;
      DEC_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IR_VALID) begin
            IR_OUT  <= IR_IN;
            NPC_OUT <= NPC_IN;
            BUSY    <= 1'b1;
            state   <= LATCH;
          end
        end
        LATCH: begin
          state <= READ;
        end
        READ: begin
          A         <= fwd_a ? WB_DATA : rf_a;
          B         <= fwd_b ? WB_DATA : rf_b;
          IMM       <= imm_c;
          DEC_VALID <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          DEC_VALID <= 1'b0;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
